// File: rtl/counter_feeder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | counter_feeder_if : event stream in, en/inc/clr strobes out         |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
interface counter_feeder_if #(
  parameter int WIDTH_P = 4
);
  logic               ev_valid;
  logic [WIDTH_P-1:0] ev_amt;
  logic               ev_ready;
  logic               clr_req;
  logic               en;
  logic [WIDTH_P-1:0] inc;
  logic               clr;

  modport master (
    output ev_valid, ev_amt, clr_req,
    input  ev_ready, en, inc, clr
  );

  modport slave (
    input  ev_valid, ev_amt, clr_req,
    output ev_ready, en, inc, clr
  );
endinterface
`default_nettype wire

// File: rtl/counter_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | counter_feeder : batches event amounts into paced en/inc/clr pulses |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module counter_feeder #(
  parameter int WIDTH_P = 4,
  parameter int GAP_P   = 4
) (
  input  logic             clk1,
  input  logic             reset_L,
  counter_feeder_if.slave  bus
);

  localparam int            GW       = $clog2(GAP_P + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_P);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH_P-1:0] acc;
  logic [WIDTH_P-1:0] acc_nxt;
  logic [GW-1:0]      gap_cnt;
  logic [GW-1:0]      gap_nxt;
  logic               clr_pend;
  logic               pend_nxt;

  logic [WIDTH_P:0]   sum;
  logic               ready;
  logic               accept;

  // One extra bit catches overflow so the accumulator can never wrap.
  assign sum    = {1'b0, acc} + {1'b0, bus.ev_amt};
  assign ready  = (state != ST_CLEAR) && !sum[WIDTH_P];
  assign accept = bus.ev_valid && ready;

  assign bus.ev_ready = ready;
  assign bus.en       = (state == ST_ISSUE);
  assign bus.inc      = (state == ST_ISSUE) ? acc : '0;
  assign bus.clr      = (state == ST_CLEAR);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    gap_nxt   = gap_cnt;
    pend_nxt  = clr_pend;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          acc_nxt = sum[WIDTH_P-1:0];
        end
        if (bus.clr_req) begin
          state_nxt = ST_CLEAR;
        end else if (acc != '0) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // The batch leaves on inc; only this cycle's event starts the next one.
        acc_nxt   = accept ? bus.ev_amt : '0;
        if (bus.clr_req) begin
          pend_nxt = 1'b1;
        end
        state_nxt = ST_GAP;
        gap_nxt   = GAP_LOAD;
      end
      ST_GAP: begin
        if (accept) begin
          acc_nxt = sum[WIDTH_P-1:0];
        end
        if (bus.clr_req || clr_pend) begin
          state_nxt = ST_CLEAR;
          pend_nxt  = 1'b0;
        end else begin
          gap_nxt = gap_cnt - 1'b1;
          if (gap_cnt <= GW'(1)) begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_CLEAR: begin
        acc_nxt   = '0;
        state_nxt = ST_GAP;
        gap_nxt   = GAP_LOAD;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk1) begin
    if (!reset_L) begin
      state    <= ST_IDLE;
      acc      <= '0;
      gap_cnt  <= '0;
      clr_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      gap_cnt  <= gap_nxt;
      clr_pend <= pend_nxt;
    end
  end

endmodule
`default_nettype wire
